// File: rtl/axi_beat_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axi_beat_gen
//  Description : Splits INCR/WRAP burst commands into single addressed beats
//                {id, addr, data} presented to a downstream FIFO through a
//                one-entry valid/ready output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_beat_gen #(
    parameter int ID_WIDTH   = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     cmd_valid,
    output logic                                     cmd_ready,
    input  logic [ID_WIDTH-1:0]                      cmd_id,
    input  logic [ADDR_WIDTH-1:0]                    cmd_addr,
    input  logic [LEN_WIDTH-1:0]                     cmd_len,
    input  logic                                     cmd_wrap,
    input  logic                                     wdata_valid,
    output logic                                     wdata_ready,
    input  logic [DATA_WIDTH-1:0]                    wdata,
    output logic [ID_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] out_AXI,
    output logic                                     dvalid,
    input  logic                                     dready,
    output logic                                     dlast,
    output logic                                     err_wrap
);

    localparam int                    c_STEP_BYTES = DATA_WIDTH / 8;
    localparam int                    c_STEP_SHIFT = $clog2(c_STEP_BYTES);
    localparam logic [ADDR_WIDTH-1:0] c_STEP       = ADDR_WIDTH'(c_STEP_BYTES);
    localparam logic [ADDR_WIDTH-1:0] c_LOW_MASK   = ADDR_WIDTH'(c_STEP_BYTES - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;

    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_mask;
    logic                  r_wrap;
    logic [LEN_WIDTH-1:0]  r_beats_left;
    logic [ID_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] r_out;
    logic                  r_dvalid;
    logic                  r_dlast;
    logic                  r_err_wrap;

    logic                  w_cmd_ready;
    logic                  w_wdata_ready;
    logic                  w_cmd_hs;
    logic                  w_wd_hs;
    logic                  w_out_hs;
    logic                  w_last_beat;
    logic                  w_wrap_legal;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;

    assign w_cmd_hs    = cmd_valid && w_cmd_ready;
    assign w_wd_hs     = wdata_valid && w_wdata_ready;
    assign w_out_hs    = r_dvalid && dready;
    assign w_last_beat = (r_beats_left == '0);

    // Only power-of-two beat counts (2/4/8/16) form a legal wrap window.
    assign w_wrap_legal = (cmd_len == LEN_WIDTH'(1)) || (cmd_len == LEN_WIDTH'(3)) ||
                          (cmd_len == LEN_WIDTH'(7)) || (cmd_len == LEN_WIDTH'(15));
    assign w_wrap_mask  = ((ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1)) << c_STEP_SHIFT) - ADDR_WIDTH'(1);

    // Step from the aligned address so an unaligned INCR start realigns on beat 2.
    assign w_addr_inc = (r_addr & ~c_LOW_MASK) + c_STEP;
    assign w_addr_nxt = r_wrap ? ((r_addr & ~r_mask) | (w_addr_inc & r_mask)) : w_addr_inc;

    // State register.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave IDLE on command accept, return after the last data beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_hs) w_state_nxt = S_BURST;
            S_BURST: if (w_wd_hs && w_last_beat) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs; both are held low while reset is asserted.
    always_comb begin
        w_cmd_ready   = 1'b0;
        w_wdata_ready = 1'b0;
        if (!rstn) begin
            w_cmd_ready   = (r_state == S_IDLE);
            w_wdata_ready = (r_state == S_BURST) && (!r_dvalid || dready);
        end
    end

    // Burst context, address sequencing and the output beat register.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_id         <= '0;
            r_addr       <= '0;
            r_mask       <= '0;
            r_wrap       <= 1'b0;
            r_beats_left <= '0;
            r_out        <= '0;
            r_dvalid     <= 1'b0;
            r_dlast      <= 1'b0;
            r_err_wrap   <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_id         <= cmd_id;
                r_addr       <= cmd_addr;
                r_beats_left <= cmd_len;
                r_wrap       <= cmd_wrap && w_wrap_legal;
                r_mask       <= w_wrap_mask;
                if (cmd_wrap && !w_wrap_legal) begin
                    r_err_wrap <= 1'b1;
                end
            end else if (w_wd_hs) begin
                r_addr <= w_addr_nxt;
                if (!w_last_beat) begin
                    r_beats_left <= r_beats_left - LEN_WIDTH'(1);
                end
            end

            if (w_wd_hs) begin
                r_out    <= {r_id, r_addr, wdata};
                r_dvalid <= 1'b1;
                r_dlast  <= w_last_beat;
            end else if (w_out_hs) begin
                r_dvalid <= 1'b0;
            end
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign wdata_ready = w_wdata_ready;
    assign out_AXI     = r_out;
    assign dvalid      = r_dvalid;
    assign dlast       = r_dlast;
    assign err_wrap    = r_err_wrap;

endmodule
`default_nettype wire

// File: tb/tb_axi_beat_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_axi_beat_gen
//  Description : Self-checking bench for axi_beat_gen; directed bursts plus
//                randomized traffic scored against a burst-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_beat_gen;

    localparam int IDW = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LW  = 4;
    localparam int OW  = IDW + AW + DW;

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [IDW-1:0]  cmd_id = '0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [LW-1:0]   cmd_len = '0;
    logic            cmd_wrap = 1'b0;
    logic            wdata_valid = 1'b0;
    logic            wdata_ready;
    logic [DW-1:0]   wdata = '0;
    logic [OW-1:0]   out_AXI;
    logic            dvalid;
    logic            dready = 1'b0;
    logic            dlast;
    logic            err_wrap;

    axi_beat_gen #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) u_dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wrap(cmd_wrap),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .out_AXI(out_AXI), .dvalid(dvalid), .dready(dready), .dlast(dlast),
        .err_wrap(err_wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic           last;
    } slot_t;

    typedef struct packed {
        logic [OW-1:0] bus;
        logic          last;
    } beat_t;

    // Model state: beats still to be filled with data, beats waiting downstream.
    slot_t q_slots[$];
    beat_t q_out[$];
    beat_t q_seen[$];
    logic  exp_err = 1'b0;
    int    wd_count = 0;

    int    n_checks = 0;
    int    n_fail   = 0;

    int    cyc = 0;
    int    wvalid_pct = 100;
    int    dready_pct = 100;
    int    hold_lo = -10;
    int    hold_hi = -10;
    logic  seq_mode = 1'b1;
    int    seq_origin = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expand a command into its beat addresses straight from the burst rules.
    function automatic void plan_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                                       input int len, input logic wrap);
        logic          legal;
        logic [AW-1:0] size;
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        legal = wrap && (len == 1 || len == 3 || len == 7 || len == 15);
        size  = AW'((len + 1) * 4);
        base  = addr - (addr % size);
        for (int i = 0; i <= len; i++) begin
            if (legal)       a = base + ((addr - base + AW'(4 * i)) % size);
            else if (i == 0) a = addr;
            else             a = (addr - (addr % 4)) + AW'(4 * i);
            q_slots.push_back('{id: id, addr: a, last: (i == len)});
        end
        if (wrap && !legal) exp_err = 1'b1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Background drivers for data and downstream back-pressure.
    always @(posedge clk) begin
        #1;
        wdata_valid = (int'($urandom_range(99)) < wvalid_pct);
        wdata       = seq_mode ? DW'(1 + wd_count - seq_origin) : $urandom;
        if (cyc >= hold_lo && cyc <= hold_hi) dready = 1'b0;
        else                                  dready = (int'($urandom_range(99)) < dready_pct);
    end

    // Monitor/scoreboard: checks current outputs, then predicts the next edge.
    logic  m_exp_cr;
    logic  m_exp_wr;
    slot_t m_slot;
    always @(negedge clk) begin
        if (rstn) begin
            q_slots.delete();
            q_out.delete();
            exp_err = 1'b0;
            check_eq("rst_cmd_ready", cmd_ready, 0);
            check_eq("rst_wdata_ready", wdata_ready, 0);
            check_eq("rst_dvalid", dvalid, 0);
            check_eq("rst_dlast", dlast, 0);
            check_eq("rst_out", out_AXI, 0);
            check_eq("rst_err_wrap", err_wrap, 0);
        end else begin
            m_exp_cr = (q_slots.size() == 0);
            m_exp_wr = (q_slots.size() != 0) && (q_out.size() == 0 || dready);
            check_eq("cmd_ready", cmd_ready, m_exp_cr);
            check_eq("wdata_ready", wdata_ready, m_exp_wr);
            check_eq("dvalid", dvalid, q_out.size() != 0);
            check_eq("err_wrap", err_wrap, exp_err);
            if (q_out.size() != 0) begin
                check_eq("out_AXI", out_AXI, q_out[0].bus);
                check_eq("dlast", dlast, q_out[0].last);
                if (dready) begin
                    q_seen.push_back('{bus: out_AXI, last: dlast});
                    void'(q_out.pop_front());
                end
            end
            if (m_exp_wr && wdata_valid) begin
                m_slot = q_slots.pop_front();
                q_out.push_back('{bus: {m_slot.id, m_slot.addr, wdata}, last: m_slot.last});
                wd_count++;
            end
            if (m_exp_cr && cmd_valid) begin
                plan_burst(cmd_id, cmd_addr, int'(cmd_len), cmd_wrap);
            end
        end
    end

    task automatic send_cmd(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                            input int len, input logic wrap);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #2;
        cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr; cmd_len = LW'(len); cmd_wrap = wrap;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (cmd_ready && !rstn) begin ok = 1'b1; break; end
        end
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        if (!ok) check_eq("cmd_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); #1;
            if (q_slots.size() == 0 && q_out.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("idle_timeout", 0, 1);
    endtask

    task automatic set_seq();
        @(posedge clk); #3;
        seq_mode   = 1'b1;
        seq_origin = wd_count;
    endtask

    task automatic expect_beat(input string tag, input int idx, input logic [IDW-1:0] id,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic last);
        if (idx >= q_seen.size()) begin
            check_eq({tag, "_missing"}, 0, 1);
        end else begin
            check_eq({tag, "_beat"}, q_seen[idx].bus, {id, addr, data});
            check_eq({tag, "_last"}, q_seen[idx].last, last);
        end
    endtask

    task automatic wait_out_addr(input logic [AW-1:0] addr);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (dvalid && out_AXI[DW +: AW] == addr) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("beat_timeout", 0, 1);
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #2;
        check_eq("reset_cmd_ready", cmd_ready, 0);
        check_eq("reset_dvalid", dvalid, 0);
        rstn = 1'b0;

        // Plain INCR burst, full throughput.
        set_seq();
        base = q_seen.size();
        send_cmd(3'd5, 32'h100, 3, 1'b0);
        wait_idle();
        for (int i = 0; i < 4; i++)
            expect_beat("incr", base + i, 3'd5, 32'h100 + AW'(4 * i), DW'(i + 1), i == 3);
        check_eq("incr_count", q_seen.size() - base, 4);

        // Same burst with downstream stalled for two cycles on beat 2.
        set_seq();
        base = q_seen.size();
        send_cmd(3'd5, 32'h100, 3, 1'b0);
        wait_out_addr(32'h100);
        hold_lo = cyc + 1;
        hold_hi = cyc + 2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check_eq("stall_out", out_AXI, {3'd5, 32'h104, 32'd2});
            check_eq("stall_wdata_ready", wdata_ready, 0);
        end
        wait_idle();
        for (int i = 0; i < 4; i++)
            expect_beat("stall", base + i, 3'd5, 32'h100 + AW'(4 * i), DW'(i + 1), i == 3);
        check_eq("stall_count", q_seen.size() - base, 4);

        // Legal WRAP of four beats.
        set_seq();
        base = q_seen.size();
        send_cmd(3'd1, 32'h1008, 3, 1'b1);
        wait_idle();
        expect_beat("wrap0", base + 0, 3'd1, 32'h1008, 1, 0);
        expect_beat("wrap1", base + 1, 3'd1, 32'h100C, 2, 0);
        expect_beat("wrap2", base + 2, 3'd1, 32'h1000, 3, 0);
        expect_beat("wrap3", base + 3, 3'd1, 32'h1004, 4, 1);
        check_eq("wrap_err", err_wrap, 0);

        // Illegal WRAP length degrades to INCR and flags the error.
        set_seq();
        base = q_seen.size();
        send_cmd(3'd2, 32'h2008, 2, 1'b1);
        wait_idle();
        expect_beat("badwrap0", base + 0, 3'd2, 32'h2008, 1, 0);
        expect_beat("badwrap1", base + 1, 3'd2, 32'h200C, 2, 0);
        expect_beat("badwrap2", base + 2, 3'd2, 32'h2010, 3, 1);
        check_eq("badwrap_err", err_wrap, 1);

        // INCR rolling over the top of the address space.
        set_seq();
        base = q_seen.size();
        send_cmd(3'd7, 32'hFFFF_FFFC, 1, 1'b0);
        wait_idle();
        expect_beat("top0", base + 0, 3'd7, 32'hFFFF_FFFC, 1, 0);
        expect_beat("top1", base + 1, 3'd7, 32'h0000_0000, 2, 1);
        check_eq("top_err_sticky", err_wrap, 1);

        // Asynchronous reset in the middle of an eight-beat burst.
        set_seq();
        send_cmd(3'd3, 32'h3000, 7, 1'b0);
        wait_out_addr(32'h3004);
        rstn = 1'b1;
        #1;
        check_eq("async_dvalid", dvalid, 0);
        check_eq("async_out", out_AXI, 0);
        check_eq("async_cmd_ready", cmd_ready, 0);
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b0;
        @(negedge clk); #1;
        check_eq("post_rst_cmd_ready", cmd_ready, 1);
        check_eq("post_rst_err", err_wrap, 0);
        set_seq();
        base = q_seen.size();
        send_cmd(3'd4, 32'h4000, 1, 1'b0);
        wait_idle();
        expect_beat("after_rst0", base + 0, 3'd4, 32'h4000, 1, 0);
        expect_beat("after_rst1", base + 1, 3'd4, 32'h4004, 2, 1);

        // Randomized traffic, back-to-back commands, random throttling.
        @(posedge clk); #3;
        seq_mode = 1'b0;
        for (int b = 0; b < 40; b++) begin
            logic [AW-1:0] a;
            logic          w;
            int            l;
            wvalid_pct = int'($urandom_range(100, 40));
            dready_pct = int'($urandom_range(100, 30));
            w = ($urandom_range(2) == 0);
            l = int'($urandom_range(15));
            a = $urandom;
            if (w) a = a & ~32'h3;
            if ($urandom_range(4) == 0) a = 32'hFFFF_FFC0 | (a & 32'h3F);
            send_cmd(IDW'($urandom), a, l, w);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/axi_beat_gen.md
AXI_BEAT_GEN -- requirements
Module: axi_beat_gen

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 3, transaction ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, beat data width; address step = DATA_WIDTH/8 bytes.
REQ-004 SHALL have parameter LEN_WIDTH, default 4, burst length field width (beats-1).
REQ-005 SHALL have port clk, input, 1, clock; all state changes on rising edge.
REQ-006 SHALL have port rstn, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port cmd_valid, input, 1, burst command offered.
REQ-008 SHALL have port cmd_ready, output, 1, command accepted this cycle if cmd_valid.
REQ-009 SHALL have port cmd_id, input, ID_WIDTH, burst ID.
REQ-010 SHALL have port cmd_addr, input, ADDR_WIDTH, start address.
REQ-011 SHALL have port cmd_len, input, LEN_WIDTH, beats-1 (0..15).
REQ-012 SHALL have port cmd_wrap, input, 1, 1 = WRAP burst, 0 = INCR.
REQ-013 SHALL have port wdata_valid, input, 1, data beat offered.
REQ-014 SHALL have port wdata_ready, output, 1, data beat consumed if wdata_valid.
REQ-015 SHALL have port wdata, input, DATA_WIDTH, beat data.
REQ-016 SHALL have port out_AXI, output, ID_WIDTH+ADDR_WIDTH+DATA_WIDTH, registered beat {id, addr, data}, id in MSBs.
REQ-017 SHALL have port dvalid, output, 1, out_AXI valid to downstream FIFO.
REQ-018 SHALL have port dready, input, 1, downstream FIFO accepts.
REQ-019 SHALL have port dlast, output, 1, final beat of burst, qualified by dvalid.
REQ-020 SHALL have port err_wrap, output, 1, sticky flag: illegal WRAP length seen.

Function
REQ-021 SHALL implement FSM IDLE/BURST; cmd_ready = (state==IDLE), combinational from state.
REQ-022 SHALL on cmd handshake latch id, addr, len, wrap; set beats_left=cmd_len; go BURST.
REQ-023 SHALL drive wdata_ready = (state==BURST) && (!dvalid || dready).
REQ-024 SHALL on wdata handshake load out_AXI={id, cur_addr, wdata}, set dvalid=1, dlast=(beats_left==0).
REQ-025 SHALL hold out_AXI, dlast stable while dvalid && !dready.
REQ-026 SHALL clear dvalid after dready handshake when no new wdata handshake occurs that cycle; simultaneous handshake reloads, dvalid stays 1.
REQ-027 SHALL after each beat decrement beats_left and advance cur_addr; after last beat return to IDLE.
REQ-028 SHALL sustain 1 beat/cycle within a burst; exactly one IDLE cycle between bursts.
REQ-029 SHALL latency: cmd accepted edge N; earliest wdata accepted edge N+1; dvalid high after edge N+1.
REQ-030 SHALL INCR: first beat uses cmd_addr unchanged; next addr = (addr with low log2(DATA_WIDTH/8) bits cleared)+DATA_WIDTH/8, modulo 2^ADDR_WIDTH (wrap at all-ones to 0).
REQ-031 SHALL WRAP (cmd_len in {1,3,7,15}): mask=(cmd_len+1)*DATA_WIDTH/8-1; all beats aligned; next = (addr & ~mask) | ((addr+step) & mask).
REQ-032 SHALL treat WRAP with other cmd_len as INCR and set err_wrap=1 at acceptance.
REQ-033 SHALL ignore cmd_valid in BURST; ignore wdata_valid in IDLE (wdata_ready=0).
REQ-034 SHALL cmd_len=0: single beat, dlast=1.

Reset
REQ-035 SHALL while rstn=1 force state=IDLE, out_AXI=0, dvalid=0, dlast=0, err_wrap=0, beats_left=0, cur_addr=0, wdata_ready=0, cmd_ready=0.
REQ-036 SHALL on reset mid-burst discard burst and pending beat immediately (asynchronous); cmd_ready=1 first cycle after rstn falls.

Verification
REQ-037 SHALL INCR id=5, addr=0x100, len=3, data 1..4, dready=1 -> beats addr 0x100,0x104,0x108,0x10C, data 1..4, dlast on 4th only.
REQ-038 SHALL same burst, dready=0 two cycles at beat 2 -> out_AXI stable {5,0x104,2}, wdata_ready=0, no beat lost or duplicated.
REQ-039 SHALL WRAP addr=0x1008, len=3 -> addrs 0x1008,0x100C,0x1000,0x1004; err_wrap=0.
REQ-040 SHALL WRAP len=2 -> INCR addrs from start, err_wrap=1 held until reset.
REQ-041 SHALL INCR addr=0xFFFFFFFC, len=1 -> addrs 0xFFFFFFFC then 0x00000000.
REQ-042 SHALL rstn=1 during beat 2 of len=7 burst -> dvalid=0 same cycle; new cmd accepted after release, beats start at its address.
